// File: rtl/iterative_alu.sv
// -----------------------------------------------------------------------------
// definitions
//   Shared data and opcode types for the integer execute path. Decode produces
//   t_alu_operation codes; the execute unit consumes them.
// -----------------------------------------------------------------------------
package definitions;

    typedef logic [31:0] t_data;

    typedef enum logic [3:0] {
        ALU_OP_INVALID           = 4'd0,
        ALU_OP_ADD               = 4'd1,
        ALU_OP_SUB               = 4'd2,
        ALU_OP_XOR               = 4'd3,
        ALU_OP_OR                = 4'd4,
        ALU_OP_AND               = 4'd5,
        ALU_OP_SHIFT_LEFT        = 4'd6,
        ALU_OP_SHIFT_RIGHT_LOGIC = 4'd7,
        ALU_OP_SHIFT_RIGHT_ARITH = 4'd8
    } t_alu_operation;

endpackage

// -----------------------------------------------------------------------------
// iterative_alu
//   Multi-cycle integer execute unit. Add/sub/xor/or/and complete in one cycle;
//   shifts iterate one bit position per clock through a single accumulator.
//   Valid/ready handshakes on both sides let the pipeline stall around the
//   variable shift latency.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous abort of any in-flight operation (highest priority)
//   in_valid     request present
//   in_ready     unit can accept a request this cycle
//   in_op        operation code
//   in_a         operand A
//   in_b         operand B; shifts use in_b[4:0] only
//   out_valid    result present
//   out_ready    consumer takes the result
//   out_result   32-bit result
//   out_zero     out_result == 0 (registered alongside the result)
//   out_illegal  request carried an unrecognised / invalid op code
// -----------------------------------------------------------------------------
module iterative_alu
    import definitions::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  t_alu_operation in_op,
    input  t_data          in_a,
    input  t_data          in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output t_data          out_result,
    output logic           out_zero,
    output logic           out_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } t_state;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // True for the three iterative shift operations.
    function automatic logic is_shift(input t_alu_operation op);
        logic r;
        case (op)
            ALU_OP_SHIFT_LEFT,
            ALU_OP_SHIFT_RIGHT_LOGIC,
            ALU_OP_SHIFT_RIGHT_ARITH: r = 1'b1;
            default:                  r = 1'b0;
        endcase
        return r;
    endfunction

    // True for every code this unit executes; anything else is flagged illegal.
    function automatic logic is_legal(input t_alu_operation op);
        logic r;
        case (op)
            ALU_OP_ADD,
            ALU_OP_SUB,
            ALU_OP_XOR,
            ALU_OP_OR,
            ALU_OP_AND,
            ALU_OP_SHIFT_LEFT,
            ALU_OP_SHIFT_RIGHT_LOGIC,
            ALU_OP_SHIFT_RIGHT_ARITH: r = 1'b1;
            default:                  r = 1'b0;
        endcase
        return r;
    endfunction

    // Single-cycle result for the non-shift operations. Carry and borrow are
    // dropped by the 32-bit truncation. Illegal codes yield zero.
    function automatic t_data alu_result(input t_alu_operation op,
                                         input t_data a,
                                         input t_data b);
        t_data r;
        case (op)
            ALU_OP_ADD: r = a + b;
            ALU_OP_SUB: r = a - b;
            ALU_OP_XOR: r = a ^ b;
            ALU_OP_OR:  r = a | b;
            ALU_OP_AND: r = a & b;
            default:    r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // One-bit shift step of the accumulator. The arithmetic right shift copies
    // bit 31 back in on every step so the sign survives any iteration count.
    function automatic t_data shift_one(input t_alu_operation op,
                                        input t_data v);
        t_data r;
        case (op)
            ALU_OP_SHIFT_LEFT:        r = {v[30:0], 1'b0};
            ALU_OP_SHIFT_RIGHT_LOGIC: r = {1'b0, v[31:1]};
            ALU_OP_SHIFT_RIGHT_ARITH: r = {v[31], v[31:1]};
            default:                  r = v;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    t_state         state_q,       state_d;
    t_data          acc_q,         acc_d;
    logic [4:0]     cnt_q,         cnt_d;
    t_alu_operation op_q,          op_d;
    logic           out_valid_q,   out_valid_d;
    t_data          out_result_q,  out_result_d;
    logic           out_zero_q,    out_zero_d;
    logic           out_illegal_q, out_illegal_d;

    logic           accept_s;
    t_data          acc_step_s;
    t_data          alu_res_s;

    // A new request can enter from IDLE, or from DONE in the same cycle the
    // current result is consumed (no bubble between back-to-back ops).
    assign in_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_DONE) && out_ready);

    // Flush discards any request presented alongside it, even with in_ready high.
    assign accept_s   = in_valid && in_ready && !flush;
    assign acc_step_s = shift_one(op_q, acc_q);
    assign alu_res_s  = alu_result(in_op, in_a, in_b);

    // Next-state and next-output computation for the whole unit.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_illegal_d = out_illegal_q;

        case (state_q)
            ST_IDLE: begin
                // Waiting for a request; the accept override below handles it.
                out_valid_d = 1'b0;
            end
            ST_SHIFT: begin
                acc_d = acc_step_s;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    // Last step: publish the shifted value together with flags.
                    state_d       = ST_DONE;
                    out_valid_d   = 1'b1;
                    out_result_d  = acc_step_s;
                    out_zero_d    = (acc_step_s == 32'h0000_0000);
                    out_illegal_d = 1'b0;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    // Backpressure: result and flags stay frozen.
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                cnt_d       = 5'd0;
            end
        endcase

        // Accept can only fire in IDLE or DONE, so it cleanly overrides the
        // state branch above.
        if (accept_s) begin
            op_d = in_op;
            if (is_shift(in_op)) begin
                acc_d = in_a;
                cnt_d = in_b[4:0];
                if (in_b[4:0] == 5'd0) begin
                    state_d       = ST_DONE;
                    out_valid_d   = 1'b1;
                    out_result_d  = in_a;
                    out_zero_d    = (in_a == 32'h0000_0000);
                    out_illegal_d = 1'b0;
                end else begin
                    state_d     = ST_SHIFT;
                    out_valid_d = 1'b0;
                end
            end else begin
                state_d       = ST_DONE;
                out_valid_d   = 1'b1;
                out_result_d  = alu_res_s;
                out_zero_d    = (alu_res_s == 32'h0000_0000);
                out_illegal_d = !is_legal(in_op);
            end
        end else begin
            op_d = op_q;
        end

        // Flush wins over every other transition.
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = 5'd0;
        end else begin
            state_d = state_d;
        end
    end

    // State and registered outputs; reset abandons any operation at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            acc_q         <= 32'h0000_0000;
            cnt_q         <= 5'd0;
            op_q          <= ALU_OP_INVALID;
            out_valid_q   <= 1'b0;
            out_result_q  <= 32'h0000_0000;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// -----------------------------------------------------------------------------
// tb_iterative_alu
//   Table-driven vectors plus hand-written multi-cycle sequences. Expected
//   results are queued when a request is accepted and compared when the unit
//   presents its result; latency is checked against the accept cycle.
// -----------------------------------------------------------------------------
module tb_iterative_alu;
    import definitions::*;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    t_alu_operation in_op;
    t_data          in_a;
    t_data          in_b;
    logic           out_valid;
    logic           out_ready;
    t_data          out_result;
    logic           out_zero;
    logic           out_illegal;

    iterative_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    typedef struct {
        t_alu_operation op;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [31:0]    res;
        logic           zero;
        logic           ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic        head_seen = 1'b0;

    // Expected values for the request currently being driven.
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
    int          exp_lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compares at negedge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                head_seen = 1'b0;
            end else begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out_valid", {31'b0, out_valid}, 32'h0);
                    end else begin
                        chk("result",  out_result,            sb[0].res);
                        chk("zero",    {31'b0, out_zero},     {31'b0, sb[0].zero});
                        chk("illegal", {31'b0, out_illegal},  {31'b0, sb[0].ill});
                        if (!head_seen) begin
                            chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                            head_seen = 1'b1;
                        end
                    end
                end
                if (flush) begin
                    sb.delete();
                    head_seen = 1'b0;
                end else begin
                    if (out_valid && out_ready && sb.size() > 0) begin
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                    end
                    if (in_valid && in_ready) begin
                        sb.push_back('{exp_res, exp_zero, exp_ill, exp_lat, cyc});
                    end
                end
            end
        end
    end

    // Present one request and hold it until accepted; tries = cycles presented.
    task automatic send(input t_alu_operation op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic z, input logic il, output int tries);
        logic acc;
        logic [4:0] n;
        n        = b[4:0];
        exp_res  = r;
        exp_zero = z;
        exp_ill  = il;
        if ((op == ALU_OP_SHIFT_LEFT || op == ALU_OP_SHIFT_RIGHT_LOGIC ||
             op == ALU_OP_SHIFT_RIGHT_ARITH) && n != 5'd0)
            exp_lat = 1 + int'(n);
        else
            exp_lat = 1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 60) begin
            @(negedge clk);
            acc = in_ready;
            tries++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", {31'b0, acc}, 32'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", sb.size(), 32'h0);
    endtask

    // Watch out_valid for a number of cycles; any assertion is an error.
    task automatic expect_quiet(input string name, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        @(posedge clk);
        #1;
        chk(name, hits, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int tries;

        vecs.push_back('{ALU_OP_ADD,               32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{ALU_OP_SUB,               32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_SHIFT_RIGHT_ARITH, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_SHIFT_RIGHT_LOGIC, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_SHIFT_LEFT,        32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_XOR,               32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_AND,               32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_OR,                32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_SHIFT_LEFT,        32'h0000_0003, 32'h0000_0004, 32'h0000_0030, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_SHIFT_RIGHT_ARITH, 32'h7FFF_0000, 32'h0000_0008, 32'h007F_FF00, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_SHIFT_RIGHT_ARITH, 32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_SHIFT_RIGHT_LOGIC, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_SUB,               32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{ALU_OP_SHIFT_LEFT,        32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0});
        vecs.push_back('{ALU_OP_INVALID,           32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1});
        vecs.push_back('{ALU_OP_ADD,               32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0});

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = ALU_OP_ADD;
        in_a      = 32'h0;
        in_b      = 32'h0;
        out_ready = 1'b1;
        exp_res   = 32'h0;
        exp_zero  = 1'b0;
        exp_ill   = 1'b0;
        exp_lat   = 1;

        // Reset state, during reset and after release.
        #2;
        chk("rst_in_ready",    {31'b0, in_ready},    32'h1);
        chk("rst_out_valid",   {31'b0, out_valid},   32'h0);
        chk("rst_out_result",  out_result,           32'h0);
        chk("rst_out_zero",    {31'b0, out_zero},    32'h0);
        chk("rst_out_illegal", {31'b0, out_illegal}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready",  {31'b0, in_ready},  32'h1);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'h0);

        // Table vectors, streamed with out_ready high.
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero, vecs[i].ill, tries);
        end
        drain();

        // Back-to-back non-shift ops: each accepted on first presentation.
        send(ALU_OP_XOR, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0, 1'b0, tries);
        chk("stream_xor_ready", tries, 32'h1);
        send(ALU_OP_AND, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0, 1'b0, tries);
        chk("stream_and_ready", tries, 32'h1);
        send(ALU_OP_OR,  32'h1234_5678, 32'h8000_0001, 32'h9234_5679, 1'b0, 1'b0, tries);
        chk("stream_or_ready", tries, 32'h1);
        drain();

        // Backpressure in DONE, then release with a new request in the same cycle.
        out_ready = 1'b0;
        send(ALU_OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, tries);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready",  {31'b0, in_ready},  32'h0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        send(ALU_OP_XOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 1'b0, tries);
        chk("bp_release_accept", tries, 32'h1);
        drain();

        // Flush in SHIFT with 10 steps remaining.
        send(ALU_OP_SHIFT_LEFT, 32'h0000_0001, 32'h0000_0014, 32'h0010_0000, 1'b0, 1'b0, tries);
        repeat (10) @(posedge clk);
        #1;
        chk("shift_in_ready", {31'b0, in_ready}, 32'h0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = ALU_OP_ADD;
        in_a     = 32'h1;
        in_b     = 32'h1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_shift_idle", {31'b0, in_ready}, 32'h1);
        expect_quiet("flush_shift_quiet", 30);

        // Flush in DONE discards a request presented while in_ready is high.
        out_ready = 1'b0;
        send(ALU_OP_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, tries);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_op     = ALU_OP_ADD;
        in_a      = 32'h7;
        in_b      = 32'h8;
        #1;
        chk("flush_done_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        expect_quiet("flush_done_quiet", 10);

        // Asynchronous reset in the middle of a shift.
        send(ALU_OP_SHIFT_RIGHT_LOGIC, 32'hFFFF_FFFF, 32'h0000_0014, 32'h0000_0FFF, 1'b0, 1'b0, tries);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid",   {31'b0, out_valid},   32'h0);
        chk("arst_out_result",  out_result,           32'h0);
        chk("arst_out_zero",    {31'b0, out_zero},    32'h0);
        chk("arst_out_illegal", {31'b0, out_illegal}, 32'h0);
        chk("arst_in_ready",    {31'b0, in_ready},    32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_quiet("arst_quiet", 30);

        // Unit works normally after the reset.
        send(ALU_OP_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, tries);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Multi-cycle integer execute unit that consumes the `t_alu_operation` codes produced by instruction decode and returns a 32-bit result. Single-cycle logic for add/sub/xor/or/and; shifts iterate one bit position per clock to keep area low. It sits between decode/operand-fetch and writeback. It uses a valid/ready handshake on both sides so the pipeline can stall around variable-latency shifts.

## Interface
Parameters: none. Types come from `definitions` (`t_data`, `t_alu_operation`).

Clocking and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous abort of any in-flight operation
- `in_valid`  in  1  request present
- `in_ready`  out  1  unit can accept a request this cycle
- `in_op`  in  `t_alu_operation`  operation
- `in_a`  in  32  operand A (`t_data`)
- `in_b`  in  32  operand B; shifts use `in_b[4:0]` only
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer takes the result
- `out_result`  out  32  result (`t_data`)
- `out_zero`  out  1  `out_result == 0`; used by `BRANCH_NE` resolution
- `out_illegal`  out  1  request carried `ALU_OP_INVALID`

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- `in_ready = (state == IDLE) || (state == DONE && out_ready)`.
- A request is accepted when `in_valid && in_ready`. Operands and op are captured at the accepting edge.
- ADD and SUB are modulo 2^32; carry and borrow are discarded.
- XOR, OR and AND are bitwise.
- Non-shift ops and INVALID:
  - Result is computed and registered at the accept edge; next state is DONE.
  - INVALID gives result 0 with `out_illegal=1`. All other ops give `out_illegal=0`.
- Shift ops:
  - The accumulator loads `in_a` and the counter loads `in_b[4:0]`.
  - If the count is 0, the next state is DONE and the result equals `in_a`.
  - Otherwise the next state is SHIFT. Each SHIFT cycle shifts the accumulator by 1 and decrements the counter. When the counter reaches 0, the next state is DONE.
  - SHIFT_LEFT fills with 0. SHIFT_RIGHT_LOGIC fills with 0. SHIFT_RIGHT_ARITH replicates bit 31 on every step.
- `out_zero` and `out_illegal` are registered together with `out_result`.
- DONE:
  - `out_valid=1`. Result and flags are held stable until `out_ready`.
  - On `out_ready` without a new request, the next state is IDLE.
  - On `out_ready` with a simultaneous accept, the next state is DONE or SHIFT for the new op. There is no bubble.
- `flush` has priority over everything else:
  - The next state is IDLE and `out_valid` drops the next cycle.
  - Any request presented in the same cycle is discarded, even if `in_ready` was high.
- `in_ready` is low in SHIFT. `in_*` are ignored there.

## Timing
- Reset values: state IDLE, `out_valid=0`, `out_result=0`, `out_zero=0`, `out_illegal=0`, counter 0. `in_ready=1` during and after reset.
- Reset asserted mid-SHIFT or in DONE abandons the operation immediately. No result is produced.
- Latency is measured from the accept edge (cycle k):
  - Non-shift, INVALID, or shift by 0: `out_valid` high in cycle k+1.
  - Shift by n (1..31): `out_valid` high in cycle k+1+n.
- Throughput is one non-shift op per cycle when `out_ready` is held high.
- `out_valid` never drops without an `out_ready` handshake, except on `flush` or reset.
- Changes of `out_ready` while `out_valid=0` have no effect.

## Test plan
- ADD a=0xFFFFFFFF, b=1 -> `out_result=0`, `out_zero=1`, `out_valid` one cycle after accept. SUB a=5, b=7 -> `0xFFFFFFFE`, `out_zero=0`.
- SHIFT_RIGHT_ARITH a=0x80000000, b=0x0000001F -> `0xFFFFFFFF` exactly 32 cycles after accept. SHIFT_RIGHT_LOGIC with the same operands -> `0x00000001`. SHIFT_LEFT a=1, b=0x20 (count 0) -> `0x00000001` after 1 cycle.
- Back-to-back XOR, AND, OR streamed with `out_ready=1` -> three results on three consecutive cycles, `in_ready` held high throughout.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE -> result, `out_zero` and `out_illegal` stable, `in_ready=0`. Release -> handshake completes; the request presented in that cycle is accepted.
- `ALU_OP_INVALID` -> `out_result=0`, `out_illegal=1` after 1 cycle. The next valid op clears `out_illegal`.
- `flush` in SHIFT with 10 steps remaining -> IDLE next cycle, no `out_valid` ever for that op. Repeat with `rst_n` pulsed mid-SHIFT -> outputs return to reset values asynchronously.
